// File: rtl/shift_right_unit.sv
// Iterative right shifter: one bit per cycle, logical or arithmetic fill.
// Result register updates only when the operation completes.
module shift_right_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   ReadData,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic               Arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   ShiftRight
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_nxt;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_work;
  logic               r_arith;
  logic [WIDTH-1:0]   r_result;

  logic               w_accept;
  logic               w_zero;
  logic               w_last;
  logic               w_fill;
  logic [WIDTH-1:0]   w_shifted;

  assign w_accept  = start && (r_state != S_SHIFT);
  assign w_zero    = (Shamt == '0);
  assign w_last    = (r_cnt <= SHAMT_W'(1));
  assign w_fill    = r_arith & r_work[WIDTH-1];
  assign w_shifted = {w_fill, r_work[WIDTH-1:1]};

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_nxt = w_zero ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (w_last)
          w_nxt = S_DONE;
      end
      S_DONE: begin
        if (start)
          w_nxt = w_zero ? S_DONE : S_SHIFT;
        else
          w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // A zero shift bypasses SHIFT, so the operand is the result directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_work   <= '0;
      r_arith  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_work  <= ReadData;
        r_cnt   <= Shamt;
        r_arith <= Arith;
        if (w_zero)
          r_result <= ReadData;
      end else if (r_state == S_SHIFT) begin
        r_work <= w_shifted;
        r_cnt  <= r_cnt - SHAMT_W'(1);
        if (w_last)
          r_result <= w_shifted;
      end
    end
  end

  assign busy       = (r_state == S_SHIFT);
  assign done       = (r_state == S_DONE);
  assign ShiftRight = r_result;

endmodule

// File: tb/tb_shift_right_unit.sv
// Scoreboard bench for shift_right_unit: expected result, done cycle
// and busy length are queued at issue and checked at each done pulse.
module tb_shift_right_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] ReadData;
  logic [2:0] Shamt;
  logic       Arith;
  logic       busy;
  logic       done;
  logic [7:0] ShiftRight;

  typedef struct {
    logic [7:0] res;
    int         cyc;
    int         nbusy;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk;
  int   n_fail;
  int   cyc;
  int   bcnt;

  shift_right_unit #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ReadData  (ReadData),
    .Shamt     (Shamt),
    .Arith     (Arith),
    .busy      (busy),
    .done      (done),
    .ShiftRight(ShiftRight)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] d,
                                       input int s,
                                       input logic a);
    logic signed [7:0] sd;
    sd = d;
    return a ? 8'(sd >>> s) : (d >> s);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy)
        bcnt++;
      if (done) begin
        check("busy_done_excl", 32'(busy), 32'd0);
        if (q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("result", 32'(ShiftRight), 32'(e.res));
          check("latency", 32'(cyc), 32'(e.cyc));
          check("busy_cycles", 32'(bcnt), 32'(e.nbusy));
        end
        bcnt = 0;
      end
    end
  end

  // Call at a negedge; start is held for exactly one accepting edge.
  task automatic issue(input logic [7:0] d,
                       input int s,
                       input logic a);
    exp_t x;
    x.res   = model(d, s, a);
    x.cyc   = cyc + 1 + s;
    x.nbusy = s;
    q.push_back(x);
    start    = 1'b1;
    ReadData = d;
    Shamt    = 3'(s);
    Arith    = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("timeout", 32'd0, 32'd1);
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done)
      check("wait_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] hold;
    n_chk    = 0;
    n_fail   = 0;
    bcnt     = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    ReadData = '0;
    Shamt    = '0;
    Arith    = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(ShiftRight), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue(8'hB4, 3, 1'b0);
    wait_empty();
    check("hold_idle", 32'(ShiftRight), 32'h16);
    issue(8'hB4, 3, 1'b1);
    wait_empty();
    issue(8'h80, 7, 1'b1);
    wait_empty();
    issue(8'h80, 7, 1'b0);
    wait_empty();
    issue(8'h7F, 7, 1'b1);
    wait_empty();
    issue(8'h5A, 0, 1'b1);
    wait_empty();

    // start during SHIFT must not disturb the running op
    issue(8'hF0, 4, 1'b0);
    start    = 1'b1;
    ReadData = 8'h0F;
    Shamt    = 3'd0;
    @(negedge clk);
    start = 1'b0;
    wait_empty();
    repeat (6) @(negedge clk);

    // back-to-back through DONE
    issue(8'hB4, 3, 1'b1);
    wait_done();
    issue(8'h40, 2, 1'b0);
    wait_empty();

    // reset during the second SHIFT cycle
    issue(8'hB4, 5, 1'b1);
    @(negedge clk);
    hold = ShiftRight;
    check("pre_rst_hold", 32'(hold), 32'h10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", 32'(ShiftRight), 32'd0);
    q.delete();
    bcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    issue(8'hC3, 2, 1'b1);
    wait_empty();

    for (int i = 0; i < 10; i++) begin
      issue(8'($urandom), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)));
      wait_empty();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_right_unit.md
SHIFT_RIGHT_UNIT -- requirements
Module: shift_right_unit

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits.
REQ-002 Parameter SHAMT_W, default 3, shift-amount width; 2**SHAMT_W SHALL equal WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled on rising clk edge.
REQ-006 ReadData  input  WIDTH  operand; sampled only on an accepted start.
REQ-007 Shamt  input  SHAMT_W  shift distance, 0..WIDTH-1; sampled only on an accepted start.
REQ-008 Arith  input  1  1 = arithmetic (sign-fill) shift, 0 = logical (zero-fill); sampled only on an accepted start.
REQ-009 busy  output  1  high while the operation is in progress (SHIFT state).
REQ-010 done  output  1  one-cycle pulse marking a valid result.
REQ-011 ShiftRight  output  WIDTH  result register.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-013 A start SHALL be accepted only in IDLE or DONE; start in SHIFT SHALL be ignored, with no effect on any register.
REQ-014 On acceptance, the block SHALL latch ReadData into a working register, Shamt into a down-counter, and Arith into a mode flag.
REQ-015 On acceptance with Shamt != 0, next state SHALL be SHIFT; with Shamt == 0, next state SHALL be DONE directly.
REQ-016 Each SHIFT cycle SHALL shift the working register right by exactly 1 bit and decrement the counter by 1.
REQ-017 Fill bit: working[WIDTH-1] if the mode flag = 1, else 0.
REQ-018 SHIFT -> DONE SHALL occur on the edge where the counter decrements from 1 to 0; otherwise the FSM SHALL stay in SHIFT.
REQ-019 On the edge entering DONE, ShiftRight SHALL load the final working value.
REQ-020 done SHALL be 1 only in DONE, for exactly one cycle per accepted operation.
REQ-021 DONE SHALL go to IDLE when start = 0, and follow REQ-015 when start = 1 (back-to-back operation).
REQ-022 Latency from the accepting edge to done high SHALL be max(Shamt,1) cycles, i.e. Shamt+1 edges counting the DONE entry when Shamt > 0.
REQ-023 busy SHALL be 1 exactly in SHIFT; busy and done SHALL never be high together.
REQ-024 ShiftRight SHALL hold its value at all times except the DONE-entry load, including across IDLE and SHIFT.
REQ-025 Results: logical = ReadData >> Shamt; arithmetic = signed ReadData >>> Shamt; the width is always WIDTH, with no overflow or carry out.
REQ-026 Shamt = WIDTH-1 SHALL yield 0x00/0x01 (logical) or 0x00/0xFF (arithmetic) according to the operand sign bit.

Reset
REQ-027 rst_n low SHALL immediately, without a clock, force the state to IDLE, the counter to 0, the working register to 0, the mode flag to 0, ShiftRight to 0, busy to 0 and done to 0.
REQ-028 Reset asserted mid-operation SHALL abandon the operation; no done SHALL be produced for it after release.
REQ-029 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-030 Logical: start, ReadData=0xB4, Shamt=3, Arith=0 -> busy for 3 cycles, then done pulse with ShiftRight=0x16.
REQ-031 Arithmetic: 0xB4, Shamt=3, Arith=1 -> ShiftRight=0xF6; 0x80, Shamt=7, Arith=1 -> 0xFF; 0x80, Shamt=7, Arith=0 -> 0x01, with done 7 cycles after accept.
REQ-032 Zero shift: 0x5A, Shamt=0 -> busy never high, done on the cycle after accept, ShiftRight=0x5A.
REQ-033 Start ignored: 0xF0, Shamt=4, Arith=0 accepted; start pulsed with 0x0F during SHIFT -> single done, ShiftRight=0x0F (from 0xF0), no second done.
REQ-034 Back-to-back: start held high through DONE with a new operand 0x40, Shamt=2 -> second operation accepted in DONE, next done gives ShiftRight=0x10.
REQ-035 Reset mid-operation: rst_n pulsed low during the 2nd SHIFT cycle -> busy, done and ShiftRight = 0 immediately; no done after release; next operation completes correctly.
